// File: rtl/lit_write_scheduler_pkg.sv
// lit_write_scheduler_pkg: shared widths, reset base and write-beat type for the literal write scheduler.
package lit_write_scheduler_pkg;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 9;
  localparam int BE_W      = 8;
  localparam int BASE_INIT = 0;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byte_valid;
  } beat_t;
endpackage

// File: rtl/lit_write_scheduler_arb.sv
// lit_bank_arb: one bank's arbiter; copy wins unless starved, literals round-robin from a one-hot base.
module lit_bank_arb
  import lit_write_scheduler_pkg::*;
#(
  parameter int NUM_PARSER = 6,
  parameter int COPY_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PARSER-1:0] i_req,
  input  logic                  i_copy_req,
  output logic [NUM_PARSER-1:0] o_lit_gnt,
  output logic                  o_copy_gnt
);
  localparam int SW = $clog2(COPY_MAX + 1);
  logic [NUM_PARSER-1:0]   r_base;
  logic [SW-1:0]           r_starve;
  logic [2*NUM_PARSER-1:0] w_dbl, w_dgnt;
  logic [NUM_PARSER-1:0]   w_rr, w_next;
  logic                    w_pend, w_full;
  // doubled request vector: subtracting the base clears the first request at or after it
  always_comb begin
    w_pend     = |i_req;
    w_full     = r_starve == SW'(COPY_MAX);
    w_dbl      = {i_req, i_req};
    w_dgnt     = w_dbl & ~(w_dbl - {{NUM_PARSER{1'b0}}, r_base});
    w_rr       = w_dgnt[NUM_PARSER-1:0] | w_dgnt[2*NUM_PARSER-1:NUM_PARSER];
    o_copy_gnt = ~rst & i_copy_req & ~(w_full & w_pend);
    o_lit_gnt  = (rst | o_copy_gnt) ? '0 : w_rr;
    w_next     = (o_lit_gnt << 1) | (o_lit_gnt >> (NUM_PARSER - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base   <= NUM_PARSER'(1) << BASE_INIT;
      r_starve <= '0;
    end else begin
      if (|o_lit_gnt) r_base <= w_next;
      r_starve <= (|o_lit_gnt || !w_pend) ? '0 : (o_copy_gnt && !w_full) ? r_starve + 1'b1 : r_starve;
    end
  end
endmodule

// File: rtl/lit_write_scheduler.sv
// lit_write_scheduler: schedules parser literal writes and copy-result writes onto history-buffer banks.
module lit_write_scheduler
  import lit_write_scheduler_pkg::*;
#(
  parameter int NUM_PARSER = 6,
  parameter int NUM_LOG    = 3,
  parameter int NUM_BANK   = 4,
  parameter int COPY_MAX   = 4,
  localparam int BW        = $clog2(NUM_BANK)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PARSER-1:0]        lit_valid,
  input  logic [NUM_PARSER*BW-1:0]     lit_bank,
  input  logic [NUM_PARSER*DATA_W-1:0] lit_data,
  input  logic [NUM_PARSER*ADDR_W-1:0] lit_address,
  input  logic [NUM_PARSER*BE_W-1:0]   lit_byte_valid,
  output logic [NUM_PARSER-1:0]        lit_ready,
  input  logic                         copy_valid,
  input  logic [BW-1:0]                copy_bank,
  input  logic [DATA_W-1:0]            copy_data,
  input  logic [ADDR_W-1:0]            copy_address,
  input  logic [BE_W-1:0]              copy_byte_valid,
  output logic                         copy_ready,
  output logic [NUM_BANK-1:0]          wr_en,
  output logic [NUM_BANK*DATA_W-1:0]   wr_data,
  output logic [NUM_BANK*ADDR_W-1:0]   wr_address,
  output logic [NUM_BANK*BE_W-1:0]     wr_byte_valid,
  output logic                         idle
);
  logic [NUM_PARSER-1:0] w_req [NUM_BANK];
  logic [NUM_PARSER-1:0] w_gnt [NUM_BANK];
  logic [NUM_LOG-1:0]    w_idx [NUM_BANK];
  beat_t                 w_beat[NUM_BANK];
  beat_t                 r_beat[NUM_BANK];
  logic [NUM_BANK-1:0]   w_copy_req, w_copy_gnt, r_wr_en;
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      w_copy_req[b] = copy_valid & (copy_bank == BW'(b));
      for (int p = 0; p < NUM_PARSER; p++)
        w_req[b][p] = lit_valid[p] & (lit_bank[p*BW +: BW] == BW'(b));
    end
  end
  // grants are one-hot per bank, so OR-encoding yields the winning parser index
  always_comb begin
    lit_ready = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      w_idx[b] = '0;
      for (int p = 0; p < NUM_PARSER; p++)
        if (w_gnt[b][p]) w_idx[b] = w_idx[b] | NUM_LOG'(p);
      lit_ready = lit_ready | w_gnt[b];
      w_beat[b] = w_copy_gnt[b] ? beat_t'{copy_data, copy_address, copy_byte_valid}
                                : beat_t'{lit_data[w_idx[b]*DATA_W +: DATA_W],
                                          lit_address[w_idx[b]*ADDR_W +: ADDR_W],
                                          lit_byte_valid[w_idx[b]*BE_W +: BE_W]};
    end
  end
  assign copy_ready = |w_copy_gnt;
  assign idle       = ~|lit_valid & ~copy_valid & ~|r_wr_en;
  assign wr_en      = r_wr_en;
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (rst) begin
        r_wr_en[b] <= 1'b0;
        r_beat[b]  <= '0;
      end else begin
        r_wr_en[b] <= w_copy_gnt[b] | (|w_gnt[b]);
        if (w_copy_gnt[b] || |w_gnt[b]) r_beat[b] <= w_beat[b];
      end
    end
  end
  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    lit_bank_arb #(.NUM_PARSER(NUM_PARSER), .COPY_MAX(COPY_MAX)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req     (w_req[b]),
      .i_copy_req(w_copy_req[b]),
      .o_lit_gnt (w_gnt[b]),
      .o_copy_gnt(w_copy_gnt[b])
    );
    assign wr_data[b*DATA_W +: DATA_W]       = r_beat[b].data;
    assign wr_address[b*ADDR_W +: ADDR_W]    = r_beat[b].address;
    assign wr_byte_valid[b*BE_W +: BE_W]     = r_beat[b].byte_valid;
  end
endmodule

// File: tb/tb_lit_write_scheduler.sv
// tb_lit_write_scheduler: directed checks of arbitration, starvation limit, latency and reset.
module tb_lit_write_scheduler;
  logic         clk = 0;
  logic         rst;
  logic [5:0]   lit_valid;
  logic [11:0]  lit_bank;
  logic [383:0] lit_data;
  logic [53:0]  lit_address;
  logic [47:0]  lit_byte_valid;
  logic [5:0]   lit_ready;
  logic         copy_valid;
  logic [1:0]   copy_bank;
  logic [63:0]  copy_data;
  logic [8:0]   copy_address;
  logic [7:0]   copy_byte_valid;
  logic         copy_ready;
  logic [3:0]   wr_en;
  logic [255:0] wr_data;
  logic [35:0]  wr_address;
  logic [31:0]  wr_byte_valid;
  logic         idle;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  lit_write_scheduler dut (
    .clk(clk), .rst(rst), .lit_valid(lit_valid), .lit_bank(lit_bank), .lit_data(lit_data),
    .lit_address(lit_address), .lit_byte_valid(lit_byte_valid), .lit_ready(lit_ready),
    .copy_valid(copy_valid), .copy_bank(copy_bank), .copy_data(copy_data),
    .copy_address(copy_address), .copy_byte_valid(copy_byte_valid), .copy_ready(copy_ready),
    .wr_en(wr_en), .wr_data(wr_data), .wr_address(wr_address), .wr_byte_valid(wr_byte_valid),
    .idle(idle)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_all;
    lit_valid = '0; lit_bank = '0; lit_data = '0; lit_address = '0; lit_byte_valid = '0;
    copy_valid = 0; copy_bank = '0; copy_data = '0; copy_address = '0; copy_byte_valid = '0;
  endtask
  task automatic lit(input int p, input int b, input logic [63:0] d, input logic [8:0] a, input logic [7:0] be);
    lit_valid[p] = 1'b1;
    lit_bank[p*2 +: 2] = 2'(b);
    lit_data[p*64 +: 64] = d;
    lit_address[p*9 +: 9] = a;
    lit_byte_valid[p*8 +: 8] = be;
  endtask
  task automatic copy(input int b, input logic [63:0] d, input logic [8:0] a, input logic [7:0] be);
    copy_valid = 1; copy_bank = 2'(b); copy_data = d; copy_address = a; copy_byte_valid = be;
  endtask
  int seq31[6] = '{0, 2, 5, 0, 2, 5};
  logic copy32[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
  initial begin
    clear_all();
    rst = 1;
    tick(); tick();
    chk("reset wr_en", 64'(wr_en), 64'h0);
    chk("reset idle", 64'(idle), 64'h1);
    chk("reset wr_data", wr_data[63:0], 64'h0);
    rst = 0;
    // single literal, one-cycle latency
    lit(0, 0, 64'hDEADBEEF_01234567, 9'h055, 8'h0F);
    #1;
    chk("single ready", 64'(lit_ready), 64'h01);
    chk("single copy_ready", 64'(copy_ready), 64'h0);
    tick();
    clear_all();
    #1;
    chk("single wr_en", 64'(wr_en), 64'h1);
    chk("single data", wr_data[63:0], 64'hDEADBEEF_01234567);
    chk("single addr", 64'(wr_address[8:0]), 64'h055);
    chk("single be", 64'(wr_byte_valid[7:0]), 64'h0F);
    chk("single busy", 64'(idle), 64'h0);
    tick();
    chk("single pulse end", 64'(wr_en), 64'h0);
    chk("single hold", wr_data[63:0], 64'hDEADBEEF_01234567);
    chk("single idle", 64'(idle), 64'h1);
    // round robin among parsers 0,2,5 on bank 1
    lit(0, 1, 64'h1000, 9'h0, 8'hFF);
    lit(2, 1, 64'h1002, 9'h2, 8'hFF);
    lit(5, 1, 64'h1005, 9'h5, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr ready %0d", i), 64'(lit_ready), 64'(6'b1 << seq31[i]));
      tick();
      chk($sformatf("rr wr_en %0d", i), 64'(wr_en), 64'h2);
      chk($sformatf("rr data %0d", i), wr_data[127:64], 64'h1000 + 64'(seq31[i]));
    end
    clear_all();
    tick();
    // copy starvation limit on bank 2
    copy(2, 64'hC0C0_C0C0_C0C0_C0C0, 9'h100, 8'hFF);
    lit(3, 2, 64'h3333_0000_0000_3333, 9'h033, 8'hF0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("starve copy_ready %0d", i), 64'(copy_ready), 64'(copy32[i]));
      chk($sformatf("starve lit_ready %0d", i), 64'(lit_ready), copy32[i] ? 64'h0 : 64'h08);
      tick();
      chk($sformatf("starve data %0d", i), wr_data[191:128],
          copy32[i] ? 64'hC0C0_C0C0_C0C0_C0C0 : 64'h3333_0000_0000_3333);
    end
    clear_all();
    tick();
    // copy and literals to three different banks together
    copy(0, 64'hAAAA, 9'h0AA, 8'h01);
    lit(1, 3, 64'hBBBB, 9'h0BB, 8'h02);
    lit(4, 2, 64'hCCCC, 9'h0CC, 8'h04);
    #1;
    chk("multi copy_ready", 64'(copy_ready), 64'h1);
    chk("multi lit_ready", 64'(lit_ready), 64'h12);
    tick();
    clear_all();
    #1;
    chk("multi wr_en", 64'(wr_en), 64'hD);
    chk("multi data0", wr_data[63:0], 64'hAAAA);
    chk("multi data3", wr_data[255:192], 64'hBBBB);
    chk("multi data2", wr_data[191:128], 64'hCCCC);
    chk("multi addr3", 64'(wr_address[35:27]), 64'h0BB);
    chk("multi be2", 64'(wr_byte_valid[23:16]), 64'h04);
    // copy beats a literal on the same bank
    copy(3, 64'h5555, 9'h1F3, 8'h80);
    lit(2, 3, 64'h2222, 9'h022, 8'h01);
    #1;
    chk("prio copy_ready", 64'(copy_ready), 64'h1);
    chk("prio lit_ready", 64'(lit_ready), 64'h0);
    tick();
    clear_all();
    #1;
    chk("prio wr_en", 64'(wr_en), 64'h8);
    chk("prio addr", 64'(wr_address[35:27]), 64'h1F3);
    tick();
    // reset mid-transfer restores base pointer
    lit(1, 0, 64'h0101, 9'h001, 8'hFF);
    lit(3, 0, 64'h0303, 9'h003, 8'hFF);
    #1;
    chk("pre-rst ready", 64'(lit_ready), 64'h02);
    tick();
    rst = 1;
    copy(2, 64'h7777, 9'h077, 8'hFF);
    #1;
    chk("rst lit_ready", 64'(lit_ready), 64'h0);
    chk("rst copy_ready", 64'(copy_ready), 64'h0);
    tick();
    chk("rst wr_en", 64'(wr_en), 64'h0);
    chk("rst wr_data", wr_data[63:0], 64'h0);
    clear_all();
    #1;
    chk("rst idle", 64'(idle), 64'h1);
    rst = 0;
    lit(1, 0, 64'h0101, 9'h001, 8'hFF);
    lit(3, 0, 64'h0303, 9'h003, 8'hFF);
    #1;
    chk("post-rst ready", 64'(lit_ready), 64'h02);
    tick();
    clear_all();
    #1;
    chk("post-rst data", wr_data[63:0], 64'h0101);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
